// File: rtl/shift_reg_sched.sv
// shift_reg_sched: two-requester command sequencer that serially loads a shift_reg through d/en/dir.
// Optional macro SHIFT_SCHED_RR_EN selects round-robin arbitration; when it is undefined,
// requester 0 wins every tie and no pointer register exists.
module shift_reg_sched #(
    parameter int  MSB = 16,
    localparam int LW  = $clog2(MSB) + 1,
    localparam int IW  = $clog2(MSB)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic          req1_valid,
    output logic          req0_ready,
    output logic          req1_ready,
    input  logic [MSB-1:0] req0_data,
    input  logic [MSB-1:0] req1_data,
    input  logic          req0_dir,
    input  logic          req1_dir,
    input  logic [LW-1:0] req0_len,
    input  logic [LW-1:0] req1_len,
    output logic          sr_d,
    output logic          sr_en,
    output logic          sr_dir,
    output logic          busy,
    output logic          done,
    output logic          done_id
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
    state_t         r_state;
    logic [MSB-1:0] r_data;
    logic [IW-1:0]  r_idx;
    logic [LW-1:0]  r_cnt;
    logic           r_d;
    logic           r_en;
    logic           r_dir;
    logic           r_busy;
    logic           r_done;
    logic           r_id;
    logic           w_idle;
    logic           w_g0;
    logic           w_g1;
    logic           w_xfer;
    logic [MSB-1:0] w_data;
    logic           w_dir;
    logic [LW-1:0]  w_len_raw;
    logic [LW-1:0]  w_len;
    logic [IW-1:0]  w_first_idx;
    logic [IW-1:0]  w_next_idx;
    assign w_idle = (r_state == S_IDLE);
`ifdef SHIFT_SCHED_RR_EN
    logic r_ptr;
    assign w_g0 = w_idle & req0_valid & (~req1_valid | ~r_ptr);
    // Round-robin pointer hands priority to the requester that was not just served.
    always_ff @(posedge clk or posedge rst)
        if (rst) r_ptr <= 1'b0;
        else if (w_xfer) r_ptr <= w_g0;
`else
    assign w_g0 = w_idle & req0_valid;
`endif
    assign w_g1       = w_idle & req1_valid & ~w_g0;
    assign w_xfer     = w_g0 | w_g1;
    assign req0_ready = w_g0;
    assign req1_ready = w_g1;
    assign w_data     = w_g1 ? req1_data : req0_data;
    assign w_dir      = w_g1 ? req1_dir : req0_dir;
    assign w_len_raw  = w_g1 ? req1_len : req0_len;
    assign w_len      = (w_len_raw > LW'(MSB)) ? LW'(MSB) : w_len_raw;
    // Left shifts feed the top bit of the field first, right shifts feed bit 0 first.
    assign w_first_idx = w_dir ? '0 : IW'(w_len - LW'(1));
    assign w_next_idx  = r_dir ? r_idx + IW'(1) : r_idx - IW'(1);
    // Sequencer: latch the granted command, stream one bit per cycle, then pulse done.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_d     <= 1'b0;
            r_en    <= 1'b0;
            r_dir   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_id    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE:
                    if (w_xfer) begin
                        r_data <= w_data;
                        r_dir  <= w_dir;
                        r_id   <= w_g1;
                        r_busy <= 1'b1;
                        if (w_len == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_SHIFT;
                            r_en    <= 1'b1;
                            r_d     <= w_data[w_first_idx];
                            r_idx   <= w_first_idx;
                            r_cnt   <= w_len - LW'(1);
                        end
                    end
                S_SHIFT:
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                        r_en    <= 1'b0;
                        r_d     <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - LW'(1);
                        r_idx <= w_next_idx;
                        r_d   <= r_data[w_next_idx];
                    end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    assign sr_d    = r_d;
    assign sr_en   = r_en;
    assign sr_dir  = r_dir;
    assign busy    = r_busy;
    assign done    = r_done;
    assign done_id = r_id;
endmodule

// File: tb/tb_shift_reg_sched.sv
// tb_shift_reg_sched: directed and randomized checks of shift_reg_sched against a behavioural model.
module tb_shift_reg_sched;
    localparam int MSB = 16;
    localparam int LW  = 5;
`ifdef SHIFT_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clk, rst;
    logic req0_valid, req1_valid, req0_ready, req1_ready;
    logic [MSB-1:0] req0_data, req1_data;
    logic req0_dir, req1_dir;
    logic [LW-1:0] req0_len, req1_len;
    logic sr_d, sr_en, sr_dir, busy, done, done_id;
    logic [MSB-1:0] sreg;
    int checks = 0;
    int errors = 0;
    bit ptr = 1'b0;

    shift_reg_sched #(.MSB(MSB)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_data(req0_data), .req1_data(req1_data),
        .req0_dir(req0_dir), .req1_dir(req1_dir),
        .req0_len(req0_len), .req1_len(req1_len),
        .sr_d(sr_d), .sr_en(sr_en), .sr_dir(sr_dir),
        .busy(busy), .done(done), .done_id(done_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural shift register fed by the scheduler's pins.
    always @(posedge clk or posedge rst)
        if (rst) sreg <= '0;
        else if (sr_en) sreg <= sr_dir ? {sr_d, sreg[MSB-1:1]} : {sreg[MSB-2:0], sr_d};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic serve(input bit v0, input bit v1, input logic [15:0] d0, input logic [15:0] d1,
                         input bit dir0, input bit dir1, input int l0, input int l1,
                         input bit hold, input bit chg);
        int w, cl;
        logic [15:0] d;
        logic [31:0] mask, s;
        bit dr, e0, eb;
        req0_valid = v0; req1_valid = v1;
        req0_data = d0;  req1_data = d1;
        req0_dir = dir0; req1_dir = dir1;
        req0_len = l0[LW-1:0]; req1_len = l1[LW-1:0];
        #1;
        e0 = v0 && (!v1 || !(RR && ptr));
        chk("ready0", {31'b0, req0_ready}, {31'b0, e0});
        chk("ready1", {31'b0, req1_ready}, {31'b0, v1 && !e0});
        if (!v0 && !v1) return;
        w  = e0 ? 0 : 1;
        d  = e0 ? d0 : d1;
        dr = e0 ? dir0 : dir1;
        cl = e0 ? l0 : l1;
        if (cl > MSB) cl = MSB;
        ptr = e0;
        @(negedge clk);
        if (!hold) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        if (chg) begin req0_data = 16'($urandom); req1_data = 16'($urandom); end
        for (int j = 0; j < cl; j++) begin
            #1;
            eb = dr ? d[j] : d[cl-1-j];
            chk("sr_en", {31'b0, sr_en}, 32'd1);
            chk("sr_d", {31'b0, sr_d}, {31'b0, eb});
            chk("sr_dir", {31'b0, sr_dir}, {31'b0, dr});
            chk("busy_shift", {31'b0, busy}, 32'd1);
            chk("done_early", {31'b0, done}, 32'd0);
            chk("ready_busy", {30'b0, req1_ready, req0_ready}, 32'd0);
            @(negedge clk);
        end
        #1;
        chk("done", {31'b0, done}, 32'd1);
        chk("done_id", {31'b0, done_id}, w);
        chk("en_off", {31'b0, sr_en}, 32'd0);
        chk("d_off", {31'b0, sr_d}, 32'd0);
        chk("busy_done", {31'b0, busy}, 32'd1);
        chk("ready_done", {30'b0, req1_ready, req0_ready}, 32'd0);
        @(negedge clk);
        #1;
        chk("busy_idle", {31'b0, busy}, 32'd0);
        chk("done_pulse", {31'b0, done}, 32'd0);
        if (cl > 0) begin
            mask = (32'd1 << cl) - 32'd1;
            s = {16'b0, sreg};
            if (dr) chk("reg_right", s >> (MSB - cl), {16'b0, d} & mask);
            else chk("reg_left", s & mask, {16'b0, d} & mask);
        end
    endtask

    initial begin
        bit v0, v1;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0;
        req0_dir = 1'b0; req1_dir = 1'b0;
        req0_len = '0; req1_len = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_outs", {26'b0, sr_d, sr_en, sr_dir, busy, done, done_id}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        serve(1, 0, 16'hA5C3, 16'h0, 0, 0, 16, 0, 0, 0);
        serve(0, 1, 16'h0, 16'h000B, 0, 1, 0, 4, 0, 0);
        serve(0, 1, 16'h0, 16'h5A3C, 0, 1, 0, 31, 0, 0);
        serve(1, 0, 16'h1234, 16'h0, 0, 0, 31, 0, 0, 0);
        serve(1, 0, 16'hFFFF, 16'h0, 0, 0, 0, 0, 1, 0);
        serve(0, 1, 16'h0, 16'h8001, 0, 0, 0, 1, 0, 0);
        repeat (4) serve(1, 1, 16'hC00D, 16'h3EEF, 1, 0, 2, 2, 1, 0);
        serve(1, 0, 16'h9E37, 16'h0, 0, 0, 16, 0, 0, 1);
        serve(1, 0, 16'h6B1D, 16'h0, 1, 0, 9, 0, 0, 1);
        // Abort a full-length command partway through.
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_data = 16'hBEEF; req0_dir = 1'b0; req0_len = 5'd16;
        #1;
        chk("rst_ready", {31'b0, req0_ready}, 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        chk("pre_rst_en", {31'b0, sr_en}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {26'b0, sr_d, sr_en, sr_dir, busy, done, done_id}, 32'd0);
        ptr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("post_rst_quiet", {29'b0, busy, done, sr_en}, 32'd0);
            @(negedge clk);
        end
        #1;
        serve(1, 1, 16'h0F0F, 16'hF0F0, 0, 1, 3, 3, 0, 0);
        for (int n = 0; n < 40; n++) begin
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            if (!v0 && !v1) v1 = 1'b1;
            serve(v0, v1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  1'($urandom), 1'($urandom));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
